// File: rtl/keypad_scan_encoder.sv
// Scans a ROWS x COLS key matrix, debounces whole frames, rejects multi-key presses and
// hands one code per press to the consumer through a single-entry valid/ready buffer.
module keypad_scan_encoder #(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int SCAN_CYCLES     = 16,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int BCD_MODE        = 1,
    parameter int CODE_W          = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [COLS-1:0]   col_drive,
    input  logic [ROWS-1:0]   row_sense,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              multi_err,
    output logic              overrun
);

    localparam int KEYS  = ROWS * COLS;
    localparam int CYC_W = $clog2(SCAN_CYCLES);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    // A press is acted on in the cycle it is recognised, so it needs no state of its own.
    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_BLOCKED
    } state_e;

    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [KEYS-1:0]   acc_q, acc_d;
    logic [KEYS-1:0]   frame_q, frame_d;
    logic              done_q, done_d;
    logic [KEYS-1:0]   prev_q, prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              held_q, held_d;
    logic              merr_q, merr_d;
    logic              ovr_q, ovr_d;

    logic last_cyc, last_col, take, stable, one_hot;

    function automatic logic [CODE_W-1:0] encode(input logic [KEYS-1:0] f);
        int idx;
        idx = 0;
        for (int i = 0; i < KEYS; i++) begin
            if (f[i]) idx = i;
        end
        if (BCD_MODE == 0) return CODE_W'(idx);
        case (idx)
            9:       return CODE_W'(10);
            10:      return '0;
            11:      return CODE_W'(11);
            default: return CODE_W'(idx + 1);
        endcase
    endfunction

    // Column scan and frame assembly; the completed frame is registered and judged next cycle.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch can infer a latch.
        cyc_d    = cyc_q + CYC_W'(1);
        col_d    = col_q;
        acc_d    = acc_q;
        frame_d  = frame_q;
        done_d   = 1'b0;
        last_cyc = (cyc_q == CYC_W'(SCAN_CYCLES - 1));
        last_col = (col_q == COL_W'(COLS - 1));
        if (last_cyc) begin
            cyc_d = '0;
            col_d = last_col ? '0 : col_q + COL_W'(1);
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (col_q == COL_W'(c)) acc_d[r*COLS+c] = row_sense[r];
                end
            end
            if (last_col) begin
                frame_d = acc_d;
                done_d  = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        held_d  = held_q;
        merr_d  = 1'b0;
        ovr_d   = ovr_q;
        stable  = 1'b0;
        take    = valid_q & key_ready;
        one_hot = (frame_q != '0) && ((frame_q & (frame_q - KEYS'(1))) == '0);
        if (take) valid_d = 1'b0;
        if (done_q) begin
            prev_d = frame_q;
            if (frame_q != prev_q)                            cnt_d = CNT_W'(1);
            else if (cnt_q != CNT_W'(DEBOUNCE_FRAMES))        cnt_d = cnt_q + CNT_W'(1);
            stable = (cnt_d == CNT_W'(DEBOUNCE_FRAMES));
        end
        if (stable) begin
            case (state_q)
                S_IDLE: begin
                    if (one_hot) begin
                        // A consumer taking the old key this cycle frees the buffer for the new one.
                        if (!valid_q || take) begin
                            code_d  = encode(frame_q);
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                        held_d  = 1'b1;
                        state_d = S_HELD;
                    end else if (frame_q != '0) begin
                        merr_d  = 1'b1;
                        state_d = S_BLOCKED;
                    end
                end
                S_HELD: begin
                    if (frame_q == '0) begin
                        held_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                S_BLOCKED: if (frame_q == '0) state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            col_q   <= '0;
            acc_q   <= '0;
            frame_q <= '0;
            done_q  <= 1'b0;
            prev_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            merr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            frame_q <= frame_d;
            done_q  <= done_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            merr_q  <= merr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign col_drive = COLS'(1) << col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign multi_err = merr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: a frame-level behavioural keypad model checked every cycle
// against a BCD and a raw-index instance, plus directed press/bounce/multi/overrun/reset cases.
module tb_keypad_scan_encoder;

    localparam int ROWS = 4;
    localparam int COLS = 3;
    localparam int SCAN = 16;
    localparam int DEB  = 3;
    localparam int KEYS = ROWS * COLS;
    localparam int F    = COLS * SCAN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_ready = 1'b1;
    logic [KEYS-1:0] keys = '0;

    logic [COLS-1:0] col_drive, col_drive_raw;
    logic [ROWS-1:0] row_sense, row_sense_raw;
    logic [3:0] key_code, key_code_raw;
    logic key_valid, key_held, multi_err, overrun;
    logic key_valid_raw, key_held_raw, multi_err_raw, overrun_raw;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [ROWS-1:0] sense(input logic [KEYS-1:0] k, input logic [COLS-1:0] col);
        logic [ROWS-1:0] rs;
        rs = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (col[c] && k[r*COLS+c]) rs[r] = 1'b1;
        return rs;
    endfunction

    assign row_sense     = sense(keys, col_drive);
    assign row_sense_raw = sense(keys, col_drive_raw);

    keypad_scan_encoder #(.ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(SCAN), .DEBOUNCE_FRAMES(DEB),
                          .BCD_MODE(1), .CODE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .col_drive(col_drive), .row_sense(row_sense),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_held(key_held), .multi_err(multi_err), .overrun(overrun));

    keypad_scan_encoder #(.ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(SCAN), .DEBOUNCE_FRAMES(DEB),
                          .BCD_MODE(0), .CODE_W(4)) dut_raw (
        .clk(clk), .rst_n(rst_n), .col_drive(col_drive_raw), .row_sense(row_sense_raw),
        .key_code(key_code_raw), .key_valid(key_valid_raw), .key_ready(key_ready),
        .key_held(key_held_raw), .multi_err(multi_err_raw), .overrun(overrun_raw));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Phone-pad code for each key index.
    int bcd_lut [KEYS] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    // Behavioural model: k counts clock edges since reset; a frame is the key matrix as seen at
    // each column's last scan cycle, and the verdict on a frame is applied one edge later.
    int unsigned k = 0;
    bit [KEYS-1:0] m_acc = '0, m_frame = '0, m_prev = '0;
    bit m_done = 0, m_valid = 0, m_held = 0, m_merr = 0, m_ovr = 0;
    int m_cnt = 0, m_mode = 0, m_code = 0, m_raw = 0, m_c = 0, m_ones = 0, m_idx = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; m_acc = '0; m_frame = '0; m_prev = '0; m_done = 0; m_cnt = 0; m_mode = 0;
            m_valid = 0; m_held = 0; m_merr = 0; m_ovr = 0; m_code = 0; m_raw = 0;
        end else begin
            m_merr = 0;
            if (m_valid && key_ready) m_valid = 0;
            if (m_done) begin
                m_cnt  = (m_frame == m_prev) ? ((m_cnt < DEB) ? m_cnt + 1 : DEB) : 1;
                m_prev = m_frame;
                if (m_cnt == DEB) begin
                    m_ones = $countones(m_frame);
                    if (m_mode == 0 && m_ones == 1) begin
                        for (int i = 0; i < KEYS; i++) if (m_frame[i]) m_idx = i;
                        if (!m_valid) begin
                            m_valid = 1; m_raw = m_idx; m_code = bcd_lut[m_idx];
                        end else m_ovr = 1;
                        m_held = 1; m_mode = 1;
                    end else if (m_mode == 0 && m_ones > 1) begin
                        m_merr = 1; m_mode = 2;
                    end else if (m_mode != 0 && m_ones == 0) begin
                        m_held = 0; m_mode = 0;
                    end
                end
            end
            m_done = 0;
            m_c = (k / SCAN) % COLS;
            if (k % SCAN == SCAN - 1) begin
                for (int r = 0; r < ROWS; r++) m_acc[r*COLS+m_c] = keys[r*COLS+m_c];
                if (m_c == COLS - 1) begin m_frame = m_acc; m_done = 1; end
            end
            k++;
        end
    end

    bit cmp_en = 0;
    bit v_prev = 0, e_prev = 0;
    int n_vrise = 0, n_merr = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("col_drive", col_drive, COLS'(1) << ((k / SCAN) % COLS));
            check("key_valid", key_valid, m_valid);
            check("key_code", key_code, m_code);
            check("key_held", key_held, m_held);
            check("multi_err", multi_err, m_merr);
            check("overrun", overrun, m_ovr);
            check("raw_valid", key_valid_raw, m_valid);
            check("raw_code", key_code_raw, m_raw);
        end
        if (key_valid && !v_prev) n_vrise++;
        if (multi_err) n_merr++;
        v_prev = key_valid;
        e_prev = multi_err;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // sel: 0 = key_valid high, 1 = key_held high, 2 = key_held low.
    task automatic wait_until(input int sel, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (sel == 0) ? key_valid : (sel == 1) ? key_held : !key_held;
        end
        #2;
    endtask

    initial begin
        bit ok;
        int v0, e0, mode, hold, rnd_rdy;
        logic [KEYS-1:0] bkey;

        // T1: key 0 pressed from reset release; first accepted on edge 3*F+1.
        keys = KEYS'(1);
        key_ready = 1'b1;
        @(posedge clk);
        cmp_en = 1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        v0 = n_vrise;
        repeat (3 * F) @(posedge clk);
        #1 check("T1 valid before 145", key_valid, 0);
        @(posedge clk);
        #1 check("T1 valid at 145", key_valid, 1);
        check("T1 code", key_code, 1);
        check("T1 held", key_held, 1);
        @(posedge clk);
        #1 check("T1 valid one cycle", key_valid, 0);
        #2 cycles(5 * F - (3 * F + 2));
        keys = '0;
        wait_until(2, 6 * F, ok);
        check("T1 release", ok, 1);
        check("T1 pulses", n_vrise - v0, 1);

        // T2: every key in turn through both code maps.
        for (int i = 0; i < KEYS; i++) begin
            keys = KEYS'(1) << i;
            wait_until(0, 6 * F, ok);
            check("T2 valid", ok, 1);
            check("T2 bcd code", key_code, bcd_lut[i]);
            check("T2 raw code", key_code_raw, i);
            keys = '0;
            cycles(5 * F);
        end

        // T3: key r=1,c=1 bounces frame by frame, then settles.
        v0 = n_vrise;
        for (int j = 0; j < 4; j++) begin
            keys = (j % 2 == 0) ? KEYS'(1) << 4 : '0;
            cycles(F);
        end
        keys = KEYS'(1) << 4;
        cycles(6 * F);
        check("T3 pulses", n_vrise - v0, 1);
        check("T3 code", key_code, 5);
        keys = '0;
        cycles(5 * F);

        // T4: two keys together are rejected; a clean press afterwards works.
        v0 = n_vrise;
        e0 = n_merr;
        keys = (KEYS'(1) << 0) | (KEYS'(1) << 8);
        cycles(6 * F);
        check("T4 multi_err pulses", n_merr - e0, 1);
        check("T4 no valid", n_vrise - v0, 0);
        check("T4 not held", key_held, 0);
        keys = '0;
        cycles(4 * F);
        keys = KEYS'(1) << 10;
        wait_until(0, 6 * F, ok);
        check("T4 valid", ok, 1);
        check("T4 code", key_code, 0);
        keys = '0;
        cycles(5 * F);

        // T5: consumer stalled; second press is dropped and overrun sticks.
        key_ready = 1'b0;
        keys = KEYS'(1);
        wait_until(0, 6 * F, ok);
        check("T5 first valid", ok, 1);
        keys = '0;
        cycles(5 * F);
        keys = KEYS'(1) << 1;
        wait_until(1, 6 * F, ok);
        check("T5 held", ok, 1);
        check("T5 code kept", key_code, 1);
        check("T5 still valid", key_valid, 1);
        check("T5 overrun", overrun, 1);
        keys = '0;
        cycles(5 * F);
        key_ready = 1'b1;
        @(posedge clk);
        #1 check("T5 valid drops", key_valid, 0);
        check("T5 overrun sticky", overrun, 1);
        #2;

        // T6: reset while a key is held and pending.
        key_ready = 1'b0;
        keys = KEYS'(1) << 2;
        wait_until(1, 6 * F, ok);
        check("T6 held", ok, 1);
        cycles(F / 2);
        rst_n = 1'b0;
        #1 check("T6 col_drive", col_drive, 1);
        check("T6 valid", key_valid, 0);
        check("T6 code", key_code, 0);
        check("T6 held", key_held, 0);
        check("T6 multi_err", multi_err, 0);
        check("T6 overrun", overrun, 0);
        keys = '0;
        key_ready = 1'b1;
        cycles(2);
        rst_n = 1'b1;

        // Randomised key patterns, bounce, ready stalls and occasional resets.
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 3);
            rnd_rdy = $urandom_range(0, 1);
            bkey = KEYS'(1) << $urandom_range(0, KEYS - 1);
            case (mode)
                0: keys = '0;
                1: keys = bkey;
                2: keys = bkey | (KEYS'(1) << $urandom_range(0, KEYS - 1));
                default: keys = bkey;
            endcase
            hold = $urandom_range(1, 5) * F + $urandom_range(0, F - 1);
            for (int j = 0; j < hold; j++) begin
                if (mode == 3 && $urandom_range(0, 15) == 0) keys = keys ^ bkey;
                key_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                cycles(1);
            end
            if ($urandom_range(0, 15) == 0) begin
                rst_n = 1'b0;
                cycles(2);
                rst_n = 1'b1;
            end
        end
        keys = '0;
        key_ready = 1'b1;
        cycles(5 * F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
